// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared encodings and sizes for the shift-and-add multiply controller.
// FSM state type, operand width and last-iteration index.
package shift_add_mult_ctrl_pkg;

  localparam int MUL_WIDTH = 8;
  localparam logic [3:0] MUL_ITER_LAST = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fulladder_8bit.sv
// 8-bit ripple-style adder: {cout_o,sum_o} = a_i + b_i + c_i.
// Ports: a_i/b_i operands, c_i carry in, sum_o sum, cout_o carry out.
module fulladder_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       c_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, c_i};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Multi-cycle unsigned 8x8->16 shift-and-add multiplier over one fulladder_8bit.
// Ports: clk, rst_n (async low), start/a/b request, busy, done strobe, product.
// Optional EARLY_TERM_EN: finish as soon as no multiplier bits remain set.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  if (WIDTH != MUL_WIDTH) begin : g_width_err
    $error("shift_add_mult_ctrl: WIDTH must equal 8");
  end

  state_e state_q, state_d;

  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   pl_q, pl_d;
  logic [WIDTH-1:0]   mr_q, mr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH-1:0]   add_y;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] sh;

  assign add_y = mr_q[0] ? m_q : '0;

  fulladder_8bit u_add (
    .a_i    (acc_q),
    .b_i    (add_y),
    .c_i    (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    pl_d    = pl_q;
    mr_d    = mr_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    // cout lands in the ACC MSB so no carry is lost.
    sh      = {add_cout, add_sum, pl_q[WIDTH-1:1]};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          mr_d    = b;
          acc_d   = '0;
          pl_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        mr_d  = mr_q >> 1;
        cnt_d = cnt_q + 4'd1;
`ifdef EARLY_TERM_EN
        // Remaining iterations would only add zero and shift.
        if (mr_d == '0) begin
          sh      = sh >> (MUL_ITER_LAST - cnt_q);
          state_d = DONE;
          prod_d  = sh;
        end
`endif
        if (cnt_q == MUL_ITER_LAST) begin
          state_d = DONE;
          prod_d  = sh;
        end
        acc_d = sh[2*WIDTH-1:WIDTH];
        pl_d  = sh[WIDTH-1:0];
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      pl_q    <= '0;
      mr_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      pl_q    <= pl_d;
      mr_q    <= mr_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = prod_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl.
// Vector table plus hand sequences for busy-start and async reset.
module tb_shift_add_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] prev_prod = '0;

  always #5 clk = ~clk;

  shift_add_mult_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  typedef struct {
    logic [7:0]  av;
    logic [7:0]  bv;
    logic [15:0] prod;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_runs(input logic [7:0] bv);
    int r;
    r = 8;
`ifdef EARLY_TERM_EN
    r = 1;
    for (int i = 0; i < 8; i++)
      if (bv[i]) r = i + 1;
`endif
    return r;
  endfunction

  task automatic mul(input logic [7:0] av, input logic [7:0] bv,
                     output logic [15:0] p, output int runs);
    bit seen;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("prod_held_at_start", {16'd0, product}, {16'd0, prev_prod});
    runs = 0;
    seen = 0;
    p = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) begin
        seen = 1;
        p = product;
      end else begin
        if (busy) runs++;
        @(negedge clk);
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t vt[8];
    logic [15:0] p;
    int runs;
    int dcount;

    vt[0] = '{8'h0F, 8'h0F, 16'h00E1};
    vt[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vt[2] = '{8'h5A, 8'h00, 16'h0000};
    vt[3] = '{8'h00, 8'hC3, 16'h0000};
    vt[4] = '{8'h03, 8'h02, 16'h0006};
    vt[5] = '{8'h80, 8'h80, 16'h4000};
    vt[6] = '{8'hFF, 8'h01, 16'h00FF};
    vt[7] = '{8'h01, 8'h80, 16'h0080};

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_product", {16'd0, product}, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      mul(vt[k].av, vt[k].bv, p, runs);
      chk($sformatf("prod_%0d", k), {16'd0, p}, {16'd0, vt[k].prod});
      chk($sformatf("runs_%0d", k), runs, exp_runs(vt[k].bv));
      repeat (2) @(negedge clk);
      chk($sformatf("hold_%0d", k), {16'd0, product}, {16'd0, vt[k].prod});
      prev_prod = vt[k].prod;
    end

    // start pulses during RUN and DONE must be ignored
    @(negedge clk);
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    p = '0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        dcount++;
        p = product;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_ign_done_pulses", dcount, 1);
    chk("busy_ign_prod", {16'd0, p}, 32'h03A8);
    chk("busy_ign_hold", {16'd0, product}, 32'h03A8);
    chk("busy_ign_idle", {31'd0, busy}, 32'd0);

    // async reset in RUN cycle 4
    @(negedge clk);
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_prod = '0;
    mul(8'h80, 8'h80, p, runs);
    chk("post_rst_prod", {16'd0, p}, 32'h4000);
    chk("post_rst_runs", runs, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
